traffic_phase_scheduler: RTL and testbench

//  Phase scheduler for a two-way (NS/EW) intersection. It sequences green, yellow and all-red phases

---
 rtl/traffic_pkg.sv | 45 ++++
 rtl/traffic_phase_scheduler_tick_gen.sv | 28 ++
 rtl/traffic_phase_scheduler.sv | 109 ++++++++++
 tb/tb_traffic_phase_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-way intersection phase scheduler.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    RED_A = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    RED_B = 3'd5
  } state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // Counter width able to hold values up to max_val.
  function automatic int unsigned width_of(input int unsigned max_val);
    return 32'($clog2(max_val)) + 32'd1;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [2:0] lamp_ns(input state_t s);
    case (s)
      NS_G:    return LAMP_G;
      NS_Y:    return LAMP_Y;
      default: return LAMP_R;
    endcase
  endfunction

  function automatic logic [2:0] lamp_ew(input state_t s);
    case (s)
      EW_G:    return LAMP_G;
      EW_Y:    return LAMP_Y;
      default: return LAMP_R;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_tick_gen.sv
// Prescaler producing a one-clock tick every CLK_HZ clocks.
module tick_gen #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0] prescaler;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      tick      <= 1'b0;
    end else if (prescaler == LAST) begin
      prescaler <= '0;
      tick      <= 1'b1;
    end else begin
      prescaler <= prescaler + PW'(1);
      tick      <= 1'b0;
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// NS/EW phase sequencer with pedestrian walk service and emergency preemption.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned GREEN_S     = 5,
  parameter int unsigned YELLOW_S    = 2,
  parameter int unsigned ALLRED_S    = 1,
  parameter int unsigned WALK_S      = 4,
  parameter int unsigned MIN_GREEN_S = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_req_ns,
  input  logic       ped_req_ew,
  input  logic [1:0] emerg_req,
  output logic [2:0] NS,
  output logic [2:0] EW,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic [2:0] phase
);

  localparam int unsigned CW = width_of(max3(GREEN_S, YELLOW_S, ALLRED_S));
  localparam logic [CW-1:0] G_LAST  = CW'(GREEN_S - 1);
  localparam logic [CW-1:0] Y_LAST  = CW'(YELLOW_S - 1);
  localparam logic [CW-1:0] AR_LAST = CW'(ALLRED_S - 1);
  localparam logic [CW-1:0] W_LAST  = CW'(WALK_S - 1);
  localparam logic [CW-1:0] MG_LAST = CW'(MIN_GREEN_S - 1);

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [1:0]    req_q;
  logic          rise_ns;
  logic          rise_ew;
  logic          pend_ns;
  logic          pend_ew;
  logic          in_green;

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign rise_ns  = ped_req_ns & ~req_q[0];
  assign rise_ew  = ped_req_ew & ~req_q[1];
  assign in_green = (state == NS_G) || (state == EW_G);
  assign phase    = state;

  // Next phase: a green held by its own preempt never yields; the opposing
  // preempt cuts it once the minimum green has elapsed.
  always_comb begin
    nxt = state;
    case (state)
      NS_G:  if (tick && !emerg_req[0] &&
                 (cnt == G_LAST || (emerg_req[1] && cnt >= MG_LAST))) nxt = NS_Y;
      NS_Y:  if (tick && cnt == Y_LAST) nxt = RED_A;
      RED_A: if (tick && cnt == AR_LAST) nxt = emerg_req[0] ? NS_G : EW_G;
      EW_G:  if (tick && !emerg_req[1] &&
                 (cnt == G_LAST || (emerg_req[0] && cnt >= MG_LAST))) nxt = EW_Y;
      EW_Y:  if (tick && cnt == Y_LAST) nxt = RED_B;
      RED_B: if (tick && cnt == AR_LAST) nxt = (emerg_req[1] && !emerg_req[0]) ? EW_G : NS_G;
      default: nxt = RED_B;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RED_B;
      cnt     <= '0;
      NS      <= LAMP_R;
      EW      <= LAMP_R;
      walk_ns <= 1'b0;
      walk_ew <= 1'b0;
      pend_ns <= 1'b0;
      pend_ew <= 1'b0;
      req_q   <= 2'b00;
    end else begin
      state <= nxt;
      NS    <= lamp_ns(nxt);
      EW    <= lamp_ew(nxt);
      req_q <= {ped_req_ew, ped_req_ns};

      if (nxt != state) cnt <= '0;
      else if (tick && !(in_green && cnt == G_LAST)) cnt <= cnt + CW'(1);

      // A request arriving on the entry edge itself is served in that green.
      if (nxt == NS_G && state != NS_G) begin
        walk_ns <= pend_ns | rise_ns;
        pend_ns <= 1'b0;
      end else begin
        if (rise_ns) pend_ns <= 1'b1;
        if (nxt != NS_G || (tick && cnt == W_LAST)) walk_ns <= 1'b0;
      end

      if (nxt == EW_G && state != EW_G) begin
        walk_ew <= pend_ew | rise_ew;
        pend_ew <= 1'b0;
      end else begin
        if (rise_ew) pend_ew <= 1'b1;
        if (nxt != EW_G || (tick && cnt == W_LAST)) walk_ew <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: expected output changes are queued, a monitor pops one per observed change.
module tb_traffic_phase_scheduler;

  localparam logic [2:0] P_NS_G = 3'd0, P_NS_Y = 3'd1, P_RED_A = 3'd2;
  localparam logic [2:0] P_EW_G = 3'd3, P_EW_Y = 3'd4, P_RED_B = 3'd5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ped_req_ns = 1'b0;
  logic       ped_req_ew = 1'b0;
  logic [1:0] emerg_req = 2'b00;
  logic [2:0] NS, EW, phase;
  logic       walk_ns, walk_ew;

  typedef struct {
    string       name;
    logic [10:0] snap;
    int          dt;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  traffic_phase_scheduler #(.CLK_HZ(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .ped_req_ns (ped_req_ns),
    .ped_req_ew (ped_req_ew),
    .emerg_req  (emerg_req),
    .NS         (NS),
    .EW         (EW),
    .walk_ns    (walk_ns),
    .walk_ew    (walk_ew),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Lamp heads per phase, straight from the decode table.
  function automatic logic [5:0] heads(input logic [2:0] ph);
    case (ph)
      P_NS_G:  return {3'b001, 3'b100};
      P_NS_Y:  return {3'b010, 3'b100};
      P_EW_G:  return {3'b100, 3'b001};
      P_EW_Y:  return {3'b100, 3'b010};
      default: return {3'b100, 3'b100};
    endcase
  endfunction

  task automatic ev(input string name, input logic [2:0] ph, input logic wns,
                    input logic wew, input int dt);
    exp_t e;
    e.name = name;
    e.snap = {ph, heads(ph), wns, wew};
    e.dt   = dt;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (cyc != n && guard < 3000);
    if (cyc != n) begin
      miscompares++;
      $display("FAIL wait_cyc timeout got=%0d want=%0d", cyc, n);
      summary();
      $fatal(1, "stimulus lost sync");
    end
  endtask

  task automatic check_all_red(input string tag);
    chk({tag, "_NS"}, NS, 3'b100);
    chk({tag, "_EW"}, EW, 3'b100);
    chk({tag, "_phase"}, phase, P_RED_B);
    chk({tag, "_walk"}, {1'b0, walk_ns, walk_ew}, 3'b000);
  endtask

  // Monitor: every change of the visible outputs must match the next queued event.
  logic [10:0] last_snap;
  int          last_cyc;
  always @(negedge clk) begin : monitor
    logic [10:0] snap;
    exp_t        e;
    snap = {phase, NS, EW, walk_ns, walk_ew};
    if (rst) begin
      last_snap = {P_RED_B, 3'b100, 3'b100, 2'b00};
      last_cyc  = 0;
    end else begin
      if (NS != 3'b100 && EW != 3'b100) begin
        miscompares++;
        $display("FAIL two_green_heads cyc=%0d NS=%b EW=%b", cyc, NS, EW);
      end
      if (!$onehot(NS) || !$onehot(EW)) begin
        miscompares++;
        $display("FAIL lamp_onehot cyc=%0d NS=%b EW=%b", cyc, NS, EW);
      end
      if (snap !== last_snap) begin
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_change cyc=%0d got=%b", cyc, snap);
        end else begin
          e = sb.pop_front();
          vectors++;
          if (snap !== e.snap || (cyc - last_cyc) != e.dt) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got={ph,NS,EW,wns,wew}=%b after %0d clk, want %b after %0d clk",
                     e.name, cyc, snap, cyc - last_cyc, e.snap, e.dt);
          end
        end
        last_snap = snap;
        last_cyc  = cyc;
      end
    end
  end

  initial begin
    #100000;
    miscompares++;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_red("reset");

    // Free run: one full 160-clk period.
    ev("t1_ns_g",  P_NS_G,  0, 0, 11);
    ev("t1_ns_y",  P_NS_Y,  0, 0, 50);
    ev("t1_red_a", P_RED_A, 0, 0, 20);
    ev("t1_ew_g",  P_EW_G,  0, 0, 10);
    ev("t1_ew_y",  P_EW_Y,  0, 0, 50);
    ev("t1_red_b", P_RED_B, 0, 0, 20);
    // NS pedestrian pulse during EW green, served once in the next NS green.
    ev("t2_ns_g_walk",   P_NS_G,  1, 0, 10);
    ev("t2_walk_off",    P_NS_G,  0, 0, 40);
    ev("t2_ns_y",        P_NS_Y,  0, 0, 10);
    ev("t2_red_a",       P_RED_A, 0, 0, 20);
    ev("t2_ew_g",        P_EW_G,  0, 0, 10);
    ev("t2_ew_y",        P_EW_Y,  0, 0, 50);
    ev("t2_red_b",       P_RED_B, 0, 0, 20);
    ev("t2_ns_g_nowalk", P_NS_G,  0, 0, 10);
    rst = 1'b0;

    wait_cyc(100); ped_req_ns = 1'b1;
    wait_cyc(101); ped_req_ns = 1'b0;

    // NS preempt from EW green entry: min green, full yellow/red, held NS green.
    ev("t3_ns_y",     P_NS_Y,  0, 0, 50);
    ev("t3_red_a",    P_RED_A, 0, 0, 20);
    ev("t3_ew_g",     P_EW_G,  0, 0, 10);
    ev("t3_ew_y_cut", P_EW_Y,  0, 0, 20);
    ev("t3_red_b",    P_RED_B, 0, 0, 20);
    ev("t3_ns_g",     P_NS_G,  0, 0, 10);
    ev("t3_release",  P_NS_Y,  0, 0, 210);
    ev("t3_red_a2",   P_RED_A, 0, 0, 20);
    ev("t3_ew_g2",    P_EW_G,  0, 0, 10);
    wait_cyc(411); emerg_req = 2'b01;
    wait_cyc(661); emerg_req = 2'b00;

    // Both preempts during RED_B: NS wins, EW served after NS drops.
    ev("t4_ew_y",      P_EW_Y,  0, 0, 50);
    ev("t4_red_b",     P_RED_B, 0, 0, 20);
    ev("t4_ns_g_hold", P_NS_G,  0, 0, 10);
    ev("t4_ns_y",      P_NS_Y,  0, 0, 70);
    ev("t4_red_a",     P_RED_A, 0, 0, 20);
    ev("t4_ew_g_hold", P_EW_G,  0, 0, 10);
    ev("t4_ew_y",      P_EW_Y,  0, 0, 50);
    ev("t4_red_b2",    P_RED_B, 0, 0, 20);
    ev("t4_ns_g",      P_NS_G,  0, 0, 10);
    wait_cyc(775); emerg_req = 2'b11;
    wait_cyc(841); emerg_req = 2'b10;
    wait_cyc(920); emerg_req = 2'b00;

    // EW request on the entry edge, then walk cut by NS preempt.
    ev("t5_ns_y",        P_NS_Y,  0, 0, 50);
    ev("t5_red_a",       P_RED_A, 0, 0, 20);
    ev("t5_ew_g_walk",   P_EW_G,  0, 1, 10);
    ev("t5_ew_y_cut",    P_EW_Y,  0, 0, 20);
    ev("t5_red_b",       P_RED_B, 0, 0, 20);
    ev("t5_ns_g",        P_NS_G,  0, 0, 10);
    ev("t5_ns_y",        P_NS_Y,  0, 0, 50);
    ev("t5_red_a2",      P_RED_A, 0, 0, 20);
    ev("t5_ew_g_nowalk", P_EW_G,  0, 0, 10);
    wait_cyc(1040); ped_req_ew = 1'b1;
    wait_cyc(1041); ped_req_ew = 1'b0; emerg_req = 2'b01;
    wait_cyc(1095); emerg_req = 2'b00;

    // Reset during EW yellow with an NS request pending.
    ev("t6_ew_y", P_EW_Y, 0, 0, 50);
    wait_cyc(1180); ped_req_ns = 1'b1;
    wait_cyc(1181); ped_req_ns = 1'b0;
    wait_cyc(1230);
    rst = 1'b1;
    #1;
    check_all_red("async_rst");
    repeat (2) @(posedge clk);
    #1;
    ev("t6_ns_g_nowalk", P_NS_G, 0, 0, 11);
    ev("t6_ns_y",        P_NS_Y, 0, 0, 50);
    rst = 1'b0;
    wait_cyc(70);

    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL events_outstanding got=%0d want=0 next=%s", sb.size(), sb[0].name);
    end
    summary();
    $finish;
  end

endmodule
